// File: rtl/regm_pkg.sv
// regm_pkg: shared types for the register-file access master.
//   regm_op_t    - command opcode encoding on cmd_op
//   regm_state_t - sequencer FSM states
//   regm_cmd_t   - captured command (op, addr, data, mask, be)
//   regm_merge   - read-modify-write merge helper
// The command struct is sized by REGM_ADDR_W / REGM_DATA_W; the top's
// ADDR_W / DATA_W defaults come from here, so widths are changed here.
package regm_pkg;

  localparam int REGM_ADDR_W = 8;
  localparam int REGM_DATA_W = 32;
  localparam int REGM_BE_W   = REGM_DATA_W / 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RMW   = 2'd2,
    OP_POLL  = 2'd3
  } regm_op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_POLL_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } regm_state_t;

  typedef struct packed {
    regm_op_t               op;
    logic [REGM_ADDR_W-1:0] addr;
    logic [REGM_DATA_W-1:0] data;
    logic [REGM_DATA_W-1:0] mask;
    logic [REGM_BE_W-1:0]   be;
  } regm_cmd_t;

  // Bits selected by mask come from val, the rest keep the old value.
  function automatic logic [REGM_DATA_W-1:0] regm_merge(
    input logic [REGM_DATA_W-1:0] old_val,
    input logic [REGM_DATA_W-1:0] val,
    input logic [REGM_DATA_W-1:0] mask
  );
    return (old_val & ~mask) | (val & mask);
  endfunction

endpackage

// File: rtl/regm_poll_ctl.sv
// regm_poll_ctl: poll bookkeeping for the access master.
//   start     - new command accepted; clears the attempt counter
//   eval      - a poll read is being sampled this cycle
//   wait_tick - FSM sits in POLL_WAIT this cycle
//   rd_data / exp_data / mask - compare operands
//   match     - (rd_data & mask) == (exp_data & mask)
//   timeout   - no match and this read is number POLL_MAX
//   gap_done  - last idle cycle of the inter-poll gap
module regm_poll_ctl
  import regm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int POLL_MAX = 255,
  parameter int POLL_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              eval,
  input  logic              wait_tick,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] mask,
  output logic              match,
  output logic              timeout,
  output logic              gap_done
);

  // A limit of 0 would never allow a read, so it behaves as 1.
  localparam int          MAX_EFF    = (POLL_MAX < 1) ? 1 : POLL_MAX;
  localparam logic [16:0] MAX_V      = 17'(MAX_EFF);
  localparam logic [7:0]  GAP_RELOAD = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

  logic [15:0] attempts_q, attempts_d;
  logic [7:0]  gap_q, gap_d;

  assign match    = ((rd_data ^ exp_data) & mask) == '0;
  // attempts_q counts reads already evaluated; the one being sampled is +1.
  assign timeout  = !match && (({1'b0, attempts_q} + 17'd1) >= MAX_V);
  assign gap_done = (gap_q == 8'd0);

  always_comb begin
    attempts_d = attempts_q;
    gap_d      = gap_q;
    if (start) begin
      attempts_d = '0;
    end else if (eval && (attempts_q != 16'hFFFF)) begin
      attempts_d = attempts_q + 16'd1;
    end
    if (eval) begin
      gap_d = GAP_RELOAD;
    end else if (wait_tick && (gap_q != 8'd0)) begin
      gap_d = gap_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      attempts_q <= '0;
      gap_q      <= '0;
    end else begin
      attempts_q <= attempts_d;
      gap_q      <= gap_d;
    end
  end

endmodule

// File: rtl/regfile_access_master.sv
// regfile_access_master: sequences WRITE / READ / RMW / POLL commands onto a
// register-file write/read port pair, one response per command.
//   cmd_*  - valid/ready command channel (accepted only in IDLE)
//   rsp_*  - valid/ready response channel (data, err)
//   wr_*   - register-file write port (wr_en for exactly one cycle)
//   rd_*   - register-file read port (rd_data combinational from rd_addr)
// Optional macro REGM_WRITE_VERIFY_EN: each write is followed by a readback
// of the same address; rsp_data = readback, rsp_err on enabled-byte mismatch.
module regfile_access_master
  import regm_pkg::*;
#(
  parameter int ADDR_W   = REGM_ADDR_W,
  parameter int DATA_W   = REGM_DATA_W,
  parameter int RD_LAT   = 0,
  parameter int POLL_MAX = 255,
  parameter int POLL_GAP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W-1:0]   cmd_mask,
  input  logic [DATA_W/8-1:0] cmd_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_be,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data
);

  localparam int BE_W = DATA_W / 8;

  regm_state_t       state_q, state_d;
  regm_cmd_t         cmd_q, cmd_d;
  logic [2:0]        lat_q, lat_d;
  logic              verify_q, verify_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic            accept, rd_last, poll_eval;
  logic            poll_match, poll_timeout, gap_done;
  logic [BE_W-1:0] be_eff;
  logic            verify_err;

  assign accept    = (state_q == ST_IDLE) && cmd_valid;
  // Last cycle of the read window: rd_data is sampled on this edge.
  assign rd_last   = (state_q == ST_READ) && (lat_q == 3'(RD_LAT));
  assign poll_eval = rd_last && !verify_q && (cmd_q.op == OP_POLL);
  // RMW always writes the full word; WRITE uses the command's enables.
  assign be_eff    = (cmd_q.op == OP_RMW) ? '1 : cmd_q.be;

`ifdef REGM_WRITE_VERIFY_EN
  logic [BE_W-1:0] byte_bad;
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_vfy
    assign byte_bad[gi] = be_eff[gi] && (rd_data[gi*8 +: 8] != wr_data_q[gi*8 +: 8]);
  end
  assign verify_err = |byte_bad;
`else
  assign verify_err = 1'b0;
`endif

  regm_poll_ctl #(
    .DATA_W   (DATA_W),
    .POLL_MAX (POLL_MAX),
    .POLL_GAP (POLL_GAP)
  ) u_poll (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .eval      (poll_eval),
    .wait_tick (state_q == ST_POLL_WAIT),
    .rd_data   (rd_data),
    .exp_data  (cmd_q.data),
    .mask      (cmd_q.mask),
    .match     (poll_match),
    .timeout   (poll_timeout),
    .gap_done  (gap_done)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    lat_d      = lat_q;
    verify_d   = verify_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d.op   = regm_op_t'(cmd_op);
          cmd_d.addr = cmd_addr;
          cmd_d.data = cmd_data;
          cmd_d.mask = cmd_mask;
          cmd_d.be   = cmd_be;
          lat_d      = '0;
          verify_d   = 1'b0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (regm_op_t'(cmd_op) == OP_WRITE) begin
            wr_addr_d = cmd_addr;
            wr_data_d = cmd_data;
            state_d   = ST_WRITE;
          end else begin
            rd_addr_d = cmd_addr;
            state_d   = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (!rd_last) begin
          lat_d = lat_q + 3'd1;
        end else begin
          lat_d      = '0;
          rsp_data_d = rd_data;
          if (verify_q) begin
            rsp_err_d = verify_err;
            state_d   = ST_RESP;
          end else begin
            case (cmd_q.op)
              OP_RMW: begin
                wr_addr_d = cmd_q.addr;
                wr_data_d = regm_merge(rd_data, cmd_q.data, cmd_q.mask);
                state_d   = ST_WRITE;
              end
              OP_POLL: begin
                if (poll_match) begin
                  rsp_err_d = 1'b0;
                  state_d   = ST_RESP;
                end else if (poll_timeout) begin
                  rsp_err_d = 1'b1;
                  state_d   = ST_RESP;
                end else begin
                  state_d = (POLL_GAP == 0) ? ST_READ : ST_POLL_WAIT;
                end
              end
              default: state_d = ST_RESP;
            endcase
          end
        end
      end
      ST_WRITE: begin
`ifdef REGM_WRITE_VERIFY_EN
        verify_d  = 1'b1;
        rd_addr_d = cmd_q.addr;
        lat_d     = '0;
        state_d   = ST_READ;
`else
        state_d = ST_RESP;
`endif
      end
      ST_POLL_WAIT: begin
        if (gap_done) begin
          state_d = ST_READ;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      lat_q      <= '0;
      verify_q   <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      lat_q      <= lat_d;
      verify_q   <= verify_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Strobe and enables decode straight from the state flop so an
  // asynchronous reset drops them at once.
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign wr_en     = (state_q == ST_WRITE);
  assign wr_be     = wr_en ? be_eff : '0;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_regfile_access_master.sv
module tb_regfile_access_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = 4;
`ifdef REGM_WRITE_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0, cmd_mask = '0;
  logic [BW-1:0] cmd_be = '0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [BW-1:0] wr_be;

  always #5 clk = ~clk;

  regfile_access_master #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .POLL_MAX(5), .POLL_GAP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Register-file model: combinational read, byte-enabled write, lockable.
  logic [DW-1:0] regs [0:255];
  bit            locked [0:255];
  assign rd_data = regs[rd_addr];
  always @(posedge clk) begin
    if (wr_en && !locked[wr_addr]) begin
      for (int b = 0; b < BW; b++) begin
        if (wr_be[b]) regs[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
  end

  typedef struct { logic [DW-1:0] data; logic err; int lat; int acc; } exp_rsp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [BW-1:0] be; } exp_wr_t;
  exp_rsp_t rsp_q[$];
  exp_wr_t  wr_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected writes and responses as the DUT presents them.
  bit            new_rsp = 1'b1;
  logic [DW-1:0] last_data;
  logic          last_err;
  always @(negedge clk) begin
    if (!rst_n) begin
      new_rsp = 1'b1;
    end else begin
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr=%h data=%h be=%b want none", wr_addr, wr_data, wr_be);
        end else begin
          exp_wr_t w;
          w = wr_q.pop_front();
          $display("write addr=%h data=%h be=%b", wr_addr, wr_data, wr_be);
          check("wr_addr", DW'(wr_addr), DW'(w.addr));
          check("wr_data", wr_data, w.data);
          check("wr_be", DW'(wr_be), DW'(w.be));
        end
      end else begin
        check("wr_be_idle", DW'(wr_be), '0);
      end
      if (rsp_valid) begin
        check("cmd_ready_busy", DW'(cmd_ready), '0);
        if (new_rsp) begin
          if (rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: got data=%h err=%b want none", rsp_data, rsp_err);
          end else begin
            exp_rsp_t e;
            e = rsp_q.pop_front();
            $display("rsp data=%h err=%b lat=%0d", rsp_data, rsp_err, cyc - e.acc);
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", DW'(rsp_err), DW'(e.err));
            check("rsp_lat", DW'(cyc - e.acc), DW'(e.lat));
          end
          last_data = rsp_data;
          last_err  = rsp_err;
          new_rsp   = 1'b0;
        end else begin
          check("rsp_data_hold", rsp_data, last_data);
          check("rsp_err_hold", DW'(rsp_err), DW'(last_err));
        end
        if (rsp_ready) new_rsp = 1'b1;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] m, input logic [BW-1:0] be, input bit push,
                       input logic [DW-1:0] ed, input logic ee, input int lat, output int acc);
    int budget = 0;
    @(negedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_be = be;
    while (!cmd_ready && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    acc = cyc;
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_accept: got no accept in %0d cycles want accept", budget);
      cmd_valid = 1'b0;
      return;
    end
    if (push) rsp_q.push_back('{ed, ee, lat, acc});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (!(rsp_q.size() == 0 && cmd_ready) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 500) begin
      total++; bad++;
      $display("FAIL wait_idle: got pending=%0d after %0d cycles want 0", rsp_q.size(), budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, DW'(cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, DW'(rsp_valid), '0);
    check({tag, "_wr_en"}, DW'(wr_en), '0);
    check({tag, "_wr_be"}, DW'(wr_be), '0);
    check({tag, "_rd_addr"}, DW'(rd_addr), '0);
    check({tag, "_wr_addr"}, DW'(wr_addr), '0);
    check({tag, "_wr_data"}, wr_data, '0);
    check({tag, "_rsp_data"}, rsp_data, '0);
    check({tag, "_rsp_err"}, DW'(rsp_err), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int budget;
    for (int i = 0; i < 256; i++) begin
      regs[i] = '0;
      locked[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    #1 rst_n = 1'b1;

    // WRITE with partial byte enables.
    wr_q.push_back('{8'h04, 32'hDEADBEEF, 4'b0011});
    issue(2'd0, 8'h04, 32'hDEADBEEF, '0, 4'b0011, 1'b1,
          VER ? 32'h0000BEEF : 32'h0, 1'b0, VER ? 5 : 2, acc);
    wait_idle();

    // READ, RD_LAT=2: three-cycle read window.
    regs[8'h04] = 32'h12345678;
    issue(2'd1, 8'h04, '0, '0, '0, 1'b1, 32'h12345678, 1'b0, 4, acc);
    wait_idle();

    // RMW.
    regs[8'h08] = 32'hFFFF0000;
    wr_q.push_back('{8'h08, 32'hFFFFAB00, 4'b1111});
    issue(2'd2, 8'h08, 32'h0000AB00, 32'h0000FF00, '0, 1'b1,
          VER ? 32'hFFFFAB00 : 32'hFFFF0000, 1'b0, VER ? 8 : 5, acc);
    wait_idle();

    // POLL that matches on the third read (bit 0 set inside the second gap).
    regs[8'h0C] = 32'h000000A0;
    issue(2'd3, 8'h0C, 32'h1, 32'h1, '0, 1'b1, 32'h000000A1, 1'b0, 18, acc);
    while (cyc < acc + 12) @(negedge clk);
    regs[8'h0C] = 32'h000000A1;
    wait_idle();

    // POLL timeout after POLL_MAX=5 reads.
    regs[8'h10] = 32'h000000F0;
    issue(2'd3, 8'h10, 32'h5, 32'hF, '0, 1'b1, 32'h000000F0, 1'b1, 32, acc);
    wait_idle();

    // Response backpressure for 10 cycles.
    rsp_ready = 1'b0;
    issue(2'd1, 8'h04, '0, '0, '0, 1'b1, 32'h12345678, 1'b0, 4, acc);
    budget = 0;
    while (!rsp_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("bp_rsp_seen", DW'(rsp_valid), 32'd1);
    repeat (10) @(negedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle();

    // Reset while in POLL_WAIT: no response expected.
    issue(2'd3, 8'h10, 32'h5, 32'hF, '0, 1'b0, '0, 1'b0, 0, acc);
    while (cyc < acc + 5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Normal operation afterwards.
    issue(2'd1, 8'h08, '0, '0, '0, 1'b1, 32'hFFFFAB00, 1'b0, 4, acc);
    wait_idle();
    issue(2'd3, 8'h0C, 32'h1, 32'h1, '0, 1'b1, 32'h000000A1, 1'b0, 4, acc);
    wait_idle();

    // WRITE upper bytes only.
    wr_q.push_back('{8'h14, 32'h11223344, 4'b1100});
    issue(2'd0, 8'h14, 32'h11223344, '0, 4'b1100, 1'b1,
          VER ? 32'h11220000 : 32'h0, 1'b0, VER ? 5 : 2, acc);
    wait_idle();

    // WRITE to a locked register.
    regs[8'h20] = 32'h5555AAAA;
    locked[8'h20] = 1'b1;
    wr_q.push_back('{8'h20, 32'hFFFFFFFF, 4'b1111});
    issue(2'd0, 8'h20, 32'hFFFFFFFF, '0, 4'b1111, 1'b1,
          VER ? 32'h5555AAAA : 32'h0, VER, VER ? 5 : 2, acc);
    wait_idle();

    repeat (3) @(negedge clk);
    check("rsp_queue_empty", DW'(rsp_q.size()), '0);
    check("wr_queue_empty", DW'(wr_q.size()), '0);
    check("reg04_final", regs[8'h04], 32'h12345678);
    check("reg14_final", regs[8'h14], 32'h11220000);
    check("reg20_locked", regs[8'h20], 32'h5555AAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
